// File: rtl/moesi_cache_line_controller.sv
// MOESI snooping controller for a direct-mapped set of cache lines.
// Sequences CPU misses and upgrades onto the bus and answers foreign snoops every cycle.
module moesi_cache_line_controller #(
    parameter int NUM_LINES = 4,
    parameter int ADDR_W    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_done,
    output logic              cpu_hit,
    output logic              cpu_writeback,
    output logic              bus_req,
    output logic [1:0]        bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_grant,
    input  logic              bus_ack,
    input  logic              bus_shared_in,
    input  logic              snoop_valid,
    input  logic [1:0]        snoop_op,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              snoop_shared,
    output logic              snoop_abort,
    output logic [2:0]        snoop_from_state
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    localparam logic [2:0] ST_I = 3'd0;
    localparam logic [2:0] ST_M = 3'd1;
    localparam logic [2:0] ST_S = 3'd2;
    localparam logic [2:0] ST_O = 3'd3;
    localparam logic [2:0] ST_E = 3'd4;

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_RWITM = 2'd2;
    localparam logic [1:0] OP_INV   = 2'd3;

    localparam logic [2:0] FROM_M   = 3'd1;
    localparam logic [2:0] FROM_O   = 3'd3;
    localparam logic [2:0] FROM_E   = 3'd4;
    localparam logic [2:0] FROM_MEM = 3'd5;

    typedef enum logic [1:0] {IDLE, LOOKUP, BUS_REQ, BUS_WAIT} fsm_t;

    fsm_t              fsm_q, fsm_d;
    logic [2:0]        line_state_q [NUM_LINES];
    logic [2:0]        line_state_d [NUM_LINES];
    logic [TAG_W-1:0]  line_tag_q   [NUM_LINES];
    logic [TAG_W-1:0]  line_tag_d   [NUM_LINES];
    logic [2:0]        post_state   [NUM_LINES];
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              req_we_q, req_we_d;
    logic [1:0]        bus_op_q, bus_op_d;
    logic              bus_req_q, bus_req_d;
    logic              cpu_done_q, cpu_done_d;
    logic              cpu_hit_q, cpu_hit_d;

    logic [IDX_W-1:0]  snp_idx;
    logic [TAG_W-1:0]  snp_tag;
    logic [2:0]        snp_cur;
    logic [2:0]        snp_next;
    logic              snp_hit;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [2:0]        lk_state;
    logic              lk_hit;
    logic              lk_victim;

    assign snp_idx = snoop_addr[IDX_W-1:0];
    assign snp_tag = snoop_addr[ADDR_W-1:IDX_W];
    assign snp_cur = line_state_q[snp_idx];
    // While we own the bus, any snoop on it is our own transaction and is ignored.
    assign snp_hit = snoop_valid && (fsm_q != BUS_WAIT) &&
                     (line_tag_q[snp_idx] == snp_tag) && (snp_cur != ST_I);

    always_comb begin
        snoop_shared     = 1'b0;
        snoop_abort      = 1'b0;
        snoop_from_state = FROM_MEM;
        snp_next         = snp_cur;
        if (snp_hit) begin
            case (snoop_op)
                OP_READ: begin
                    snoop_shared = 1'b1;
                    case (snp_cur)
                        ST_M: begin snp_next = ST_O; snoop_abort = 1'b1; snoop_from_state = FROM_M; end
                        ST_O: begin snoop_abort = 1'b1; snoop_from_state = FROM_O; end
                        ST_E: begin snp_next = ST_S; snoop_abort = 1'b1; snoop_from_state = FROM_E; end
                        default: ;
                    endcase
                end
                OP_RWITM: begin
                    snp_next = ST_I;
                    case (snp_cur)
                        ST_M: begin snoop_abort = 1'b1; snoop_from_state = FROM_M; end
                        ST_O: begin snoop_abort = 1'b1; snoop_from_state = FROM_O; end
                        ST_E: begin snoop_abort = 1'b1; snoop_from_state = FROM_E; end
                        default: ;
                    endcase
                end
                OP_INV:  snp_next = ST_I;
                default: ;
            endcase
        end
    end

    // The snoop update lands first; the CPU side then works on the post-snoop view.
    always_comb begin
        post_state = line_state_q;
        if (snp_hit) post_state[snp_idx] = snp_next;
    end

    assign req_idx   = req_addr_q[IDX_W-1:0];
    assign req_tag   = req_addr_q[ADDR_W-1:IDX_W];
    assign lk_state  = post_state[req_idx];
    assign lk_hit    = (line_tag_q[req_idx] == req_tag) && (lk_state != ST_I);
    assign lk_victim = (line_tag_q[req_idx] != req_tag) && ((lk_state == ST_M) || (lk_state == ST_O));

    always_comb begin
        fsm_d        = fsm_q;
        line_state_d = post_state;
        line_tag_d   = line_tag_q;
        req_addr_d   = req_addr_q;
        req_we_d     = req_we_q;
        bus_op_d     = bus_op_q;
        bus_req_d    = bus_req_q;
        cpu_done_d   = 1'b0;
        cpu_hit_d    = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (cpu_req) begin
                    fsm_d      = LOOKUP;
                    req_addr_d = cpu_addr;
                    req_we_d   = cpu_we;
                end
            end
            LOOKUP: begin
                if (lk_hit && (!req_we_q || lk_state == ST_M || lk_state == ST_E)) begin
                    if (req_we_q) line_state_d[req_idx] = ST_M;
                    cpu_done_d = 1'b1;
                    cpu_hit_d  = 1'b1;
                    fsm_d      = IDLE;
                end else begin
                    fsm_d     = BUS_REQ;
                    bus_req_d = 1'b1;
                    bus_op_d  = lk_hit ? OP_INV : (req_we_q ? OP_RWITM : OP_READ);
                end
            end
            BUS_REQ: begin
                // An upgrade whose copy was snooped away must now fetch the line.
                if (bus_op_q == OP_INV && !lk_hit) bus_op_d = OP_RWITM;
                if (bus_grant) fsm_d = BUS_WAIT;
            end
            BUS_WAIT: begin
                if (bus_ack) begin
                    fsm_d               = IDLE;
                    bus_req_d           = 1'b0;
                    bus_op_d            = OP_NONE;
                    cpu_done_d          = 1'b1;
                    cpu_hit_d           = (bus_op_q == OP_INV);
                    line_tag_d[req_idx] = req_tag;
                    if (bus_op_q == OP_READ) line_state_d[req_idx] = bus_shared_in ? ST_S : ST_E;
                    else                     line_state_d[req_idx] = ST_M;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q        <= IDLE;
            line_state_q <= '{default: ST_I};
            line_tag_q   <= '{default: '0};
            req_addr_q   <= '0;
            req_we_q     <= 1'b0;
            bus_op_q     <= OP_NONE;
            bus_req_q    <= 1'b0;
            cpu_done_q   <= 1'b0;
            cpu_hit_q    <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            line_state_q <= line_state_d;
            line_tag_q   <= line_tag_d;
            req_addr_q   <= req_addr_d;
            req_we_q     <= req_we_d;
            bus_op_q     <= bus_op_d;
            bus_req_q    <= bus_req_d;
            cpu_done_q   <= cpu_done_d;
            cpu_hit_q    <= cpu_hit_d;
        end
    end

    assign cpu_done      = cpu_done_q;
    assign cpu_hit       = cpu_hit_q;
    assign bus_req       = bus_req_q;
    assign bus_op        = bus_op_q;
    assign bus_addr      = req_addr_q;
    // Writeback is flagged during LOOKUP itself, once the post-snoop victim state is known.
    assign cpu_writeback = (fsm_q == LOOKUP) && lk_victim;

endmodule

// File: tb/tb_moesi_cache_line_controller.sv
// Bench for the MOESI line controller: directed scenarios then randomized traffic
// checked against a transaction-level coherency model.
module tb_moesi_cache_line_controller;
    localparam int ST_I = 0, ST_M = 1, ST_S = 2, ST_O = 3, ST_E = 4;
    localparam int OP_READ = 1, OP_RWITM = 2, OP_INV = 3;
    localparam int FROM_M = 1, FROM_O = 3, FROM_E = 4, FROM_MEM = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0] cpu_addr = '0;
    logic       cpu_done, cpu_hit, cpu_writeback, bus_req;
    logic [1:0] bus_op;
    logic [7:0] bus_addr;
    logic       bus_grant = 1'b0, bus_ack = 1'b0, bus_shared_in = 1'b0;
    logic       snoop_valid = 1'b0;
    logic [1:0] snoop_op = '0;
    logic [7:0] snoop_addr = '0;
    logic       snoop_shared, snoop_abort;
    logic [2:0] snoop_from_state;

    int vectors = 0;
    int miscompares = 0;
    int m_state [4];
    int m_tag   [4];

    moesi_cache_line_controller #(.NUM_LINES(4), .ADDR_W(8)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_done(cpu_done), .cpu_hit(cpu_hit), .cpu_writeback(cpu_writeback),
        .bus_req(bus_req), .bus_op(bus_op), .bus_addr(bus_addr),
        .bus_grant(bus_grant), .bus_ack(bus_ack), .bus_shared_in(bus_shared_in),
        .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_addr(snoop_addr),
        .snoop_shared(snoop_shared), .snoop_abort(snoop_abort), .snoop_from_state(snoop_from_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_line(input logic [1:0] idx);
        check("line_state", 32'(dut.line_state_q[idx]), m_state[idx]);
        check("line_tag", 32'(dut.line_tag_q[idx]), m_tag[idx]);
    endtask

    // One CPU transaction with the model's prediction of every observable step.
    task automatic do_cpu(input logic [7:0] addr, input logic we, input logic sh, input int gw, input int aw);
        logic [1:0] idx;
        int tg, st, op;
        bit hit, fast, wb;
        idx  = addr[1:0];
        tg   = int'(addr[7:2]);
        st   = m_state[idx];
        hit  = (m_tag[idx] == tg) && (st != ST_I);
        fast = hit && (!we || st == ST_M || st == ST_E);
        wb   = (m_tag[idx] != tg) && (st == ST_M || st == ST_O);
        op   = hit ? OP_INV : (we ? OP_RWITM : OP_READ);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr;
        step(); #1;
        check("lookup_writeback", 32'(cpu_writeback), 32'(wb));
        check("lookup_no_done", 32'(cpu_done), 0);
        if (fast) begin
            step(); #1;
            check("hit_done", 32'(cpu_done), 1);
            check("hit_flag", 32'(cpu_hit), 1);
            check("hit_no_bus", 32'(bus_req), 0);
            if (we) m_state[idx] = ST_M;
        end else begin
            step(); #1;
            check("miss_bus_req", 32'(bus_req), 1);
            check("miss_bus_op", 32'(bus_op), op);
            check("miss_bus_addr", 32'(bus_addr), 32'(addr));
            repeat (gw) step();
            bus_grant = 1'b1;
            step();
            bus_grant = 1'b0;
            repeat (aw) step();
            #1 check("wait_bus_req", 32'(bus_req), 1);
            bus_ack = 1'b1; bus_shared_in = sh;
            step();
            bus_ack = 1'b0; bus_shared_in = 1'b0;
            #1;
            check("miss_done", 32'(cpu_done), 1);
            check("miss_hit_flag", 32'(cpu_hit), 32'(op == OP_INV));
            check("miss_bus_released", 32'(bus_req), 0);
            m_tag[idx]   = tg;
            m_state[idx] = (op == OP_READ) ? (sh ? ST_S : ST_E) : ST_M;
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        check_line(idx);
        step();
        check("done_is_pulse", 32'(cpu_done), 0);
    endtask

    // One snoop presented while the controller is idle.
    task automatic do_snoop(input logic [1:0] op, input logic [7:0] addr);
        logic [1:0] idx;
        int st, e_sh, e_ab, e_fr, nxt;
        bit match;
        idx   = addr[1:0];
        st    = m_state[idx];
        match = (m_tag[idx] == int'(addr[7:2])) && (st != ST_I);
        e_sh = 0; e_ab = 0; e_fr = FROM_MEM; nxt = st;
        if (match) begin
            e_sh = (int'(op) == OP_READ) ? 1 : 0;
            if (int'(op) != OP_INV) begin
                case (st)
                    ST_M: begin e_ab = 1; e_fr = FROM_M; end
                    ST_O: begin e_ab = 1; e_fr = FROM_O; end
                    ST_E: begin e_ab = 1; e_fr = FROM_E; end
                    default: ;
                endcase
            end
            if (int'(op) == OP_READ) nxt = (st == ST_M) ? ST_O : ((st == ST_E) ? ST_S : st);
            else                     nxt = ST_I;
        end
        snoop_valid = 1'b1; snoop_op = op; snoop_addr = addr;
        #1;
        check("snoop_shared", 32'(snoop_shared), e_sh);
        check("snoop_abort", 32'(snoop_abort), e_ab);
        check("snoop_from", 32'(snoop_from_state), e_fr);
        step();
        snoop_valid = 1'b0; snoop_op = '0; snoop_addr = '0;
        m_state[idx] = nxt;
        check_line(idx);
    endtask

    initial begin
        m_state = '{default: ST_I};
        m_tag   = '{default: 0};
        repeat (3) step();
        check("rst_cpu_done", 32'(cpu_done), 0);
        check("rst_cpu_hit", 32'(cpu_hit), 0);
        check("rst_writeback", 32'(cpu_writeback), 0);
        check("rst_bus_req", 32'(bus_req), 0);
        check("rst_bus_op", 32'(bus_op), 0);
        check("rst_bus_addr", 32'(bus_addr), 0);
        check("rst_snoop_from", 32'(snoop_from_state), FROM_MEM);
        reset = 1'b0;
        step();

        // T1..T5 directed scenarios
        do_cpu(8'h12, 1'b0, 1'b0, 0, 0);
        check("t1_line_e", 32'(dut.line_state_q[2]), ST_E);
        do_cpu(8'h12, 1'b1, 1'b0, 0, 0);
        do_snoop(2'(OP_READ), 8'h12);
        check("t3_line_o", 32'(dut.line_state_q[2]), ST_O);
        do_cpu(8'h12, 1'b1, 1'b0, 1, 1);
        do_cpu(8'h16, 1'b0, 1'b1, 0, 2);

        // T6: upgrade converted to RWITM by a snoop during BUS_REQ
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h16;
        step(); step(); #1;
        check("t6_op_inv", 32'(bus_op), OP_INV);
        snoop_valid = 1'b1; snoop_op = 2'(OP_INV); snoop_addr = 8'h16;
        #1 check("t6_snoop_no_abort", 32'(snoop_abort), 0);
        step();
        snoop_valid = 1'b0;
        #1;
        check("t6_op_rwitm", 32'(bus_op), OP_RWITM);
        check("t6_bus_req", 32'(bus_req), 1);
        check("t6_line_i", 32'(dut.line_state_q[2]), ST_I);
        bus_grant = 1'b1; step(); bus_grant = 1'b0;
        bus_ack = 1'b1; step(); bus_ack = 1'b0;
        #1;
        check("t6_done", 32'(cpu_done), 1);
        check("t6_hit", 32'(cpu_hit), 0);
        check("t6_line_m", 32'(dut.line_state_q[2]), ST_M);
        cpu_req = 1'b0; cpu_we = 1'b0;
        step();

        // Reset while in BUS_WAIT
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h1A;
        step(); step();
        bus_grant = 1'b1; step(); bus_grant = 1'b0;
        #1 check("t6_wait_bus_req", 32'(bus_req), 1);
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        step();
        reset = 1'b0;
        #1;
        check("t6_rst_bus_req", 32'(bus_req), 0);
        check("t6_rst_done", 32'(cpu_done), 0);
        m_state = '{default: ST_I};
        m_tag   = '{default: 0};
        check_line(2'd0); check_line(2'd1); check_line(2'd2); check_line(2'd3);
        step();

        // Randomized traffic against the model
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 2) == 0)
                do_snoop(2'($urandom_range(1, 3)), 8'($urandom_range(0, 15)));
            else
                do_cpu(8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
